regfile_transfer_sequencer: RTL and testbench

REGFILE_TRANSFER_SEQUENCER -- requirements
Module: regfile_transfer_sequencer

---
 rtl/regfile_transfer_sequencer.sv | 149 ++++++++++++++
 tb/tb_regfile_transfer_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_transfer_sequencer.sv
// Block-transfer sequencer: moves the registers selected by reg_list to or from
// consecutive memory words, lowest register first; a loaded R15 goes to the PC.
module regfile_transfer_sequencer #(
   parameter int N = 4,
   parameter int M = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         is_load,
   input  logic [15:0]  reg_list,
   input  logic [M-1:0] base_addr,
   output logic [N-1:0] rf_a1,
   input  logic [M-1:0] rf_rd1,
   output logic         rf_we3,
   output logic [N-1:0] rf_a3,
   output logic [M-1:0] rf_wd3,
   output logic         mem_req,
   output logic         mem_we,
   output logic [M-1:0] mem_addr,
   output logic [M-1:0] mem_wdata,
   input  logic         mem_ready,
   input  logic [M-1:0] mem_rdata,
   output logic         pc_we,
   output logic [M-1:0] pc_wd,
   output logic         busy,
   output logic         done,
   output logic [M-1:0] final_addr,
   output logic [1:0]   dbg_state
);

   // Memory handshake: mem_req is held with address/data stable until the
   // cycle where mem_req and mem_ready are both high; that cycle completes the access.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WB   = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam logic [N-1:0] PC_IDX = N'(15);

   state_t       state, state_nx;
   logic [15:0]  mask_q, mask_nx, mask_clr;
   logic [M-1:0] addr_q, addr_nx;
   logic         load_q, load_nx;
   logic [M-1:0] data_q, data_nx;
   logic [N-1:0] k_q, k_nx;
   logic [N-1:0] cur_k;

   // Lowest set bit of the remaining mask is the current register.
   always_comb begin
      cur_k = '0;
      for (int i = 15; i >= 0; i--) begin
         if (mask_q[i]) cur_k = N'(i);
      end
   end

   assign mask_clr = mask_q & (mask_q - 16'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= IDLE;
         mask_q <= '0;
         addr_q <= '0;
         load_q <= 1'b0;
         data_q <= '0;
         k_q    <= '0;
      end else begin
         state  <= state_nx;
         mask_q <= mask_nx;
         addr_q <= addr_nx;
         load_q <= load_nx;
         data_q <= data_nx;
         k_q    <= k_nx;
      end
   end

   always_comb begin
      state_nx   = state;
      mask_nx    = mask_q;
      addr_nx    = addr_q;
      load_nx    = load_q;
      data_nx    = data_q;
      k_nx       = k_q;
      rf_a1      = '0;
      rf_we3     = 1'b0;
      rf_a3      = '0;
      rf_wd3     = '0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      pc_we      = 1'b0;
      pc_wd      = '0;
      done       = 1'b0;
      final_addr = '0;
      case (state)
         IDLE: begin
            if (start) begin
               mask_nx  = reg_list;
               addr_nx  = base_addr;
               load_nx  = is_load;
               state_nx = (reg_list != 16'd0) ? XFER : DONE;
            end
         end
         XFER: begin
            mem_req   = 1'b1;
            mem_we    = !load_q;
            mem_addr  = addr_q;
            rf_a1     = cur_k;
            mem_wdata = rf_rd1;
            if (mem_ready) begin
               mask_nx = mask_clr;
               addr_nx = addr_q + M'(4);
               if (load_q) begin
                  data_nx  = mem_rdata;
                  k_nx     = cur_k;
                  state_nx = WB;
               end else begin
                  state_nx = (mask_clr == 16'd0) ? DONE : XFER;
               end
            end
         end
         WB: begin
            // R15 is the PC: it is redirected, never written through port 3.
            if (k_q == PC_IDX) begin
               pc_we = 1'b1;
               pc_wd = data_q;
            end else begin
               rf_we3 = 1'b1;
               rf_a3  = k_q;
               rf_wd3 = data_q;
            end
            state_nx = (mask_q == 16'd0) ? DONE : XFER;
         end
         DONE: begin
            done       = 1'b1;
            final_addr = addr_q;
            state_nx   = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign busy      = (state != IDLE);
   assign dbg_state = state;

endmodule

// File: tb/tb_regfile_transfer_sequencer.sv
// Directed and randomized checks of the block-transfer sequencer against a
// transfer-list reference model built from the register mask.
module tb_regfile_transfer_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        is_load;
   logic [15:0] reg_list;
   logic [31:0] base_addr;
   logic [3:0]  rf_a1;
   logic [31:0] rf_rd1;
   logic        rf_we3;
   logic [3:0]  rf_a3;
   logic [31:0] rf_wd3;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        pc_we;
   logic [31:0] pc_wd;
   logic        busy;
   logic        done;
   logic [31:0] final_addr;
   logic [1:0]  dbg_state;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] regs [16];
   logic        rf_loaded = 1'b0;
   logic [31:0] fixed_rdata_q [$];

   regfile_transfer_sequencer #(.N(4), .M(32)) dut (
      .clk(clk), .reset(reset), .start(start), .is_load(is_load),
      .reg_list(reg_list), .base_addr(base_addr),
      .rf_a1(rf_a1), .rf_rd1(rf_rd1),
      .rf_we3(rf_we3), .rf_a3(rf_a3), .rf_wd3(rf_wd3),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .pc_we(pc_we), .pc_wd(pc_wd),
      .busy(busy), .done(done), .final_addr(final_addr), .dbg_state(dbg_state)
   );

   // clock / reset environment
   always #5 clk = ~clk;

   // bench register file: combinational read, write on rising edge
   assign rf_rd1 = regs[rf_a1];
   always @(posedge clk) begin
      if (!rf_loaded) begin
         for (int i = 0; i < 16; i++) regs[i] <= $urandom;
         rf_loaded <= 1'b1;
      end else if (rf_we3) begin
         regs[rf_a3] <= rf_wd3;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ctl"}, {60'd0, rf_we3, mem_req, mem_we, pc_we}, 64'd0);
      chk({tag, "_stat"}, {60'd0, busy, done, dbg_state}, 64'd0);
      chk({tag, "_addr"}, {56'd0, rf_a1, rf_a3}, 64'd0);
      chk({tag, "_d1"}, {rf_wd3, mem_addr}, 64'd0);
      chk({tag, "_d2"}, {mem_wdata, pc_wd}, 64'd0);
      chk({tag, "_fin"}, {32'd0, final_addr}, 64'd0);
   endtask

   // Runs one operation starting at a falling edge. The model expands the mask
   // into an ordered list of (register, address) transfers and then walks it.
   task automatic run_op(input logic ld, input logic [15:0] m, input logic [31:0] b,
                         input int ready_pct, input int hold, input int abort_wb,
                         output int cyc);
      logic [3:0]  exp_reg_q [$];
      logic [31:0] exp_addr_q [$];
      logic [31:0] a;
      logic [31:0] exp_final;
      logic [3:0]  wb_reg;
      logic [3:0]  r;
      logic [31:0] wb_data;
      logic [31:0] old;
      logic        wb_pend;
      logic        fin;
      logic        rdy;
      int          wb_cnt;
      int          stalls;
      a = b;
      for (int i = 0; i < 16; i++) begin
         if (m[i]) begin
            exp_reg_q.push_back(4'(i));
            exp_addr_q.push_back(a);
            a = a + 32'd4;
         end
      end
      exp_final = a;
      chk("idle_busy", {63'd0, busy}, 64'd0);
      start = 1'b1; is_load = ld; reg_list = m; base_addr = b; mem_ready = 1'b0;
      cyc = 0; wb_pend = 1'b0; wb_cnt = 0; fin = 1'b0; stalls = hold;
      wb_reg = '0; wb_data = '0;
      while (!fin && cyc < 200) begin
         @(negedge clk);
         cyc++;
         mem_ready = 1'($urandom_range(0, 1));
         if (wb_pend) begin
            wb_cnt++;
            if (wb_cnt == abort_wb) begin
               reset = 1'b1; start = 1'b0;
               #1;
               chk_all_zero("abort");
               old = regs[wb_reg];
               @(posedge clk); #1;
               chk("abort_no_write", {32'd0, regs[wb_reg]}, {32'd0, old});
               @(negedge clk);
               reset = 1'b0;
               chk("abort_no_done", {62'd0, busy, done}, 64'd0);
               return;
            end
            chk("wb_mem_req", {63'd0, mem_req}, 64'd0);
            chk("wb_done", {63'd0, done}, 64'd0);
            if (wb_reg == 4'd15) begin
               chk("wb_pc_we", {62'd0, pc_we, rf_we3}, {62'd0, 2'b10});
               chk("wb_pc_wd", {32'd0, pc_wd}, {32'd0, wb_data});
            end else begin
               chk("wb_rf_we", {62'd0, rf_we3, pc_we}, {62'd0, 2'b10});
               chk("wb_rf_a3", {60'd0, rf_a3}, {60'd0, wb_reg});
               chk("wb_rf_wd3", {32'd0, rf_wd3}, {32'd0, wb_data});
            end
            wb_pend = 1'b0;
         end else if (exp_reg_q.size() != 0) begin
            chk("xf_req", {61'd0, mem_req, mem_we, done}, {61'd0, 1'b1, !ld, 1'b0});
            chk("xf_addr", {32'd0, mem_addr}, {32'd0, exp_addr_q[0]});
            chk("xf_rf_a1", {60'd0, rf_a1}, {60'd0, exp_reg_q[0]});
            chk("xf_no_wr", {62'd0, rf_we3, pc_we}, 64'd0);
            if (!ld) chk("xf_wdata", {32'd0, mem_wdata}, {32'd0, regs[exp_reg_q[0]]});
            if (stalls > 0) begin
               rdy = 1'b0;
               stalls--;
            end else begin
               rdy = ($urandom_range(0, 99) < ready_pct);
            end
            mem_ready = rdy;
            mem_rdata = (rdy && fixed_rdata_q.size() != 0) ? fixed_rdata_q.pop_front() : $urandom;
            if (rdy) begin
               r = exp_reg_q.pop_front();
               void'(exp_addr_q.pop_front());
               if (ld) begin
                  wb_pend = 1'b1; wb_reg = r; wb_data = mem_rdata;
               end
            end
         end else begin
            chk("dn_done", {62'd0, done, busy}, {62'd0, 2'b11});
            chk("dn_final", {32'd0, final_addr}, {32'd0, exp_final});
            chk("dn_quiet", {61'd0, mem_req, rf_we3, pc_we}, 64'd0);
            fin = 1'b1;
         end
         if (fin) begin
            start = 1'b0;
         end else begin
            // operands and start are noise while busy and must be ignored
            start = 1'($urandom_range(0, 1));
            is_load = 1'($urandom_range(0, 1));
            reg_list = 16'($urandom);
            base_addr = $urandom;
         end
      end
      if (!fin) chk("timeout", 64'd0, 64'd1);
      @(negedge clk);
      chk("post_idle", {62'd0, busy, done}, 64'd0);
   endtask

   initial begin
      int cyc;
      reset = 1'b1; start = 1'b0; is_load = 1'b0; reg_list = '0;
      base_addr = '0; mem_ready = 1'b0; mem_rdata = '0;
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      run_op(1'b0, 16'h0013, 32'h0000_0100, 100, 0, 0, cyc);
      chk("store13_cycles", 64'(cyc), 64'd4);

      fixed_rdata_q.push_back(32'h0000_AAAA);
      fixed_rdata_q.push_back(32'h0000_BBBB);
      run_op(1'b1, 16'h8004, 32'h0000_0200, 100, 0, 0, cyc);
      chk("load8004_cycles", 64'(cyc), 64'd5);

      run_op(1'b0, 16'h0000, 32'h0000_0300, 100, 0, 0, cyc);
      chk("empty_cycles", 64'(cyc), 64'd1);

      run_op(1'b1, 16'h0001, 32'h0000_0500, 100, 3, 0, cyc);
      chk("stall_cycles", 64'(cyc), 64'd6);

      run_op(1'b1, 16'h000F, 32'h0000_0400, 100, 0, 2, cyc);
      run_op(1'b1, 16'h00F0, 32'h0000_0600, 100, 0, 0, cyc);
      chk("after_abort_cycles", 64'(cyc), 64'd9);

      run_op(1'b0, 16'h0003, 32'hFFFF_FFFC, 100, 0, 0, cyc);
      chk("wrap_cycles", 64'(cyc), 64'd3);

      run_op(1'b0, 16'h8000, 32'h0000_0700, 70, 0, 0, cyc);

      for (int t = 0; t < 30; t++) begin
         logic        ld;
         logic [15:0] m;
         logic [31:0] b;
         ld = 1'($urandom_range(0, 1));
         m = ($urandom_range(0, 5) == 0) ? 16'h0000 : 16'($urandom);
         b = $urandom & 32'hFFFF_FFFC;
         run_op(ld, m, b, 60, 0, 0, cyc);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
